mult_result_accumulator: RTL

Downstream consumer of the 16x16 shift-and-add (peasant) multiplier. Watches the multiplier's 32-bit product and its completion flag, and adds each completed product into a wide accumulator. After a programmed number of terms it presents the sum through a valid/ready handshake. Together with the multiplier it forms a serial multiply-accumulate path for dot-product style workloads.

---
 rtl/mult_result_accumulator.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mult_result_accumulator.sv
// mult_result_accumulator
// Accumulates completed products from the shift-and-add multiplier into a
// wide unsigned sum. A product is taken on each rising edge of done_i. After
// N_TERMS products the sum is frozen and offered on a valid/ready handshake.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   prod_i      multiplier product (unsigned, W_IN bits)
//   done_i      multiplier completion level; rising edge marks prod_i valid
//   clr_i       synchronous soft clear of the accumulation in progress
//   acc_rdy_i   consumer ready for the final sum
//   acc_o       running / final sum (W_ACC bits)
//   acc_vld_o   final sum valid
//   term_cnt_o  number of terms accumulated so far
//   ovf_o       sticky carry-out-of-W_ACC flag for this accumulation
//   drop_o      one-cycle pulse: product arrived while holding and was discarded
module mult_result_accumulator #(
    parameter int W_IN    = 32,
    parameter int W_ACC   = 40,
    parameter int N_TERMS = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [W_IN-1:0]    prod_i,
    input  logic               done_i,
    input  logic               clr_i,
    input  logic               acc_rdy_i,
    output logic [W_ACC-1:0]   acc_o,
    output logic               acc_vld_o,
    output logic [7:0]         term_cnt_o,
    output logic               ovf_o,
    output logic               drop_o
);

    localparam int         W_SUM     = W_ACC + 1;
    localparam logic [7:0] N_TERMS_C = 8'(N_TERMS);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               done_q_r;
    logic [W_ACC-1:0]   acc_r;
    logic [W_ACC-1:0]   acc_nxt_s;
    logic [7:0]         cnt_r;
    logic [7:0]         cnt_nxt_s;
    logic               ovf_r;
    logic               ovf_nxt_s;
    logic               drop_r;
    logic               drop_nxt_s;
    logic               take_s;
    logic               last_term_s;
    logic [W_SUM-1:0]   sum_s;
    logic [W_ACC-1:0]   prod_ext_s;

    // Rising-edge detect on done_i plus the widened add with carry-out bit.
    always_comb begin
        take_s      = done_i & ~done_q_r;
        prod_ext_s  = W_ACC'(prod_i);
        sum_s       = {1'b0, acc_r} + W_SUM'(prod_i);
        last_term_s = ((cnt_r + 8'd1) == N_TERMS_C);
    end

    // State register; clr_i is folded into the next-state logic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (clr_i) begin
            state_nxt_s = ST_ACCUM;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (take_s && last_term_s) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    // A take during the handshake starts the next sum; with a
                    // single-term accumulation that term is already complete.
                    if (acc_rdy_i) begin
                        if (take_s && (N_TERMS_C == 8'd1)) begin
                            state_nxt_s = ST_HOLD;
                        end else begin
                            state_nxt_s = ST_ACCUM;
                        end
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                default: begin
                    state_nxt_s = ST_ACCUM;
                end
            endcase
        end
    end

    // Datapath next values: sum, term count, sticky overflow and drop pulse.
    always_comb begin
        acc_nxt_s  = acc_r;
        cnt_nxt_s  = cnt_r;
        ovf_nxt_s  = ovf_r;
        drop_nxt_s = 1'b0;
        if (clr_i) begin
            // A coincident take is silently discarded here.
            acc_nxt_s = {W_ACC{1'b0}};
            cnt_nxt_s = 8'd0;
            ovf_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (take_s) begin
                        acc_nxt_s = sum_s[W_ACC-1:0];
                        cnt_nxt_s = cnt_r + 8'd1;
                        ovf_nxt_s = ovf_r | sum_s[W_ACC];
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end
                ST_HOLD: begin
                    if (acc_rdy_i) begin
                        ovf_nxt_s = 1'b0;
                        if (take_s) begin
                            acc_nxt_s = prod_ext_s;
                            cnt_nxt_s = 8'd1;
                        end else begin
                            acc_nxt_s = {W_ACC{1'b0}};
                            cnt_nxt_s = 8'd0;
                        end
                    end else if (take_s) begin
                        drop_nxt_s = 1'b1;
                    end else begin
                        drop_nxt_s = 1'b0;
                    end
                end
                default: begin
                    acc_nxt_s = {W_ACC{1'b0}};
                    cnt_nxt_s = 8'd0;
                    ovf_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers and the done_i history bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q_r <= 1'b0;
            acc_r    <= {W_ACC{1'b0}};
            cnt_r    <= 8'd0;
            ovf_r    <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            done_q_r <= done_i;
            acc_r    <= acc_nxt_s;
            cnt_r    <= cnt_nxt_s;
            ovf_r    <= ovf_nxt_s;
            drop_r   <= drop_nxt_s;
        end
    end

    // Outputs come straight from registers; no input-to-output path.
    always_comb begin
        acc_o      = acc_r;
        acc_vld_o  = (state_r == ST_HOLD);
        term_cnt_o = cnt_r;
        ovf_o      = ovf_r;
        drop_o     = drop_r;
    end

endmodule
